fft_sched: RTL and testbench
============================

# fft_sched

Round-robin scheduler that shares one `fft_process` spectrum engine between NUM_CH ADC channels. Each run is sequenced from arbitration through the engine's enable/done handshake to a drain phase, and the engine is never re-enabled while it still reports done. During each run the block muxes the granted channel's samples into the engine and tracks the peak magnitude bin, which it publishes as a per-run result. A watchdog resets a hung engine and reports the fault.

## Interface
Parameters:
- NUM_CH, 4: number of requesting channels (2..8).
- FFT_SIZE, 2048: engine transform length; peak search covers bins 1..FFT_SIZE/2-1.
- TIMEOUT_CYCLES, 1_000_000: maximum clk cycles allowed in RUN before abort.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ch_req  in  NUM_CH  level request per channel, held until that channel's ch_done.
- ch_adc_data  in  16*NUM_CH  Q1.15 samples; channel k occupies bits [16k+15:16k].
- ch_adc_valid  in  NUM_CH  per-channel sample strobe.
- ch_grant  out  NUM_CH  one-hot grant, or all zero.
- ch_done  out  NUM_CH  one-cycle completion pulse to the granted channel.
- fft_rst_n  out  1  engine reset, active-low.
- fft_enable  out  1  engine enable.
- fft_adc_input  out  16  sample forwarded to the engine.
- fft_adc_valid  out  1  forwarded sample strobe.
- fft_magnitude  in  28  engine magnitude, Q13.15, unsigned.
- fft_bin_index  in  11  engine bin index.
- fft_magnitude_valid  in  1  engine magnitude strobe.
- fft_processing_done  in  1  engine done level.
- peak_ch  out  3  channel of the published result.
- peak_bin  out  11  bin index of the maximum magnitude.
- peak_mag  out  28  maximum magnitude.
- peak_valid  out  1  one-cycle result strobe.
- timeout_err  out  1  one-cycle watchdog abort strobe.

## Operation
- States: IDLE, RUN, DRAIN, RECOVER, RESULT.
- **IDLE**
  - If any ch_req is set, pick the winner round-robin, searching from last_grant+1 with wraparound.
  - On the winner: latch ch_grant, set fft_enable=1, clear the peak registers and the watchdog, go to RUN.
  - last_grant resets to NUM_CH-1, so channel 0 wins the first arbitration.
- **RUN**
  - fft_adc_input = granted channel's data slice (combinational).
  - fft_adc_valid = ch_adc_valid[g] while in RUN, else 0 (combinational).
  - Samples on non-granted channels are ignored.
  - On fft_magnitude_valid with 1 <= fft_bin_index < FFT_SIZE/2: if fft_magnitude > running max (strict), load max and bin. Ties keep the lower bin.
  - Bin 0 (DC) and bins >= FFT_SIZE/2 are never considered.
  - If fft_processing_done=1: set fft_enable<=0, go to DRAIN.
  - Else if watchdog == TIMEOUT_CYCLES-1: set fft_enable<=0, set the aborted flag, go to RECOVER.
- **DRAIN**
  - Hold fft_enable=0 until fft_processing_done=0, then go to RESULT.
- **RECOVER**
  - Drive fft_rst_n=0 for exactly 2 cycles, then go to RESULT.
- **RESULT** (one cycle)
  - Pulse ch_done[g], clear ch_grant, set last_grant=g.
  - If not aborted: pulse peak_valid; peak_ch/peak_bin/peak_mag hold the result until the next RESULT.
  - If aborted: pulse timeout_err; peak_valid stays 0 and the peak outputs keep their previous values.
  - Go to IDLE.
- A ch_req drop during a run does not abort it; ch_done still pulses.
- A new request from the just-served channel is eligible again only after the other requesters are scanned.
- If no magnitude qualifies in a run, the result is peak_bin=0, peak_mag=0.

## Timing
- Reset values:
  - fft_rst_n=0 while rst is high, 1 from the first cycle after rst falls.
  - All other outputs are 0; ch_grant=0; state=IDLE.
- rst is sampled every cycle. Reset mid-run returns to IDLE and holds the engine in reset.
- Request first seen high in cycle N gives ch_grant and fft_enable high in cycle N+1.
- fft_processing_done rising in cycle M gives fft_enable low in M+1.
- The engine clears done in the cycle after it sees enable low. RESULT is the cycle after done is sampled low, so ch_done/peak_valid occur no earlier than M+3.
- Peak registers update the cycle after the qualifying fft_magnitude_valid.
- The earliest next grant is the cycle after RESULT; at least one IDLE cycle separates runs.
- Timeout: the abort decision is made in the cycle where the watchdog equals TIMEOUT_CYCLES-1. fft_rst_n is low for the next 2 cycles, and timeout_err comes 1 cycle after that.

## Test plan
- Single request, ch1 tone; the model engine reports bin 100 with magnitude 0x0100000, and all other bins 0x0000010 → peak_ch=1, peak_bin=100, peak_mag=0x0100000, one ch_done[1] pulse, one peak_valid.
- ch0 and ch2 request continuously → grants go 0, 2, 0, 2; never two grant bits set; ch_done matches each grant.
- Tie: bins 5 and 7 both report 0x0000800 → peak_bin=5. Bin 0 reports 0xFFFFFFF → ignored.
- Engine never asserts done, TIMEOUT_CYCLES=64 → fft_enable drops after 64 RUN cycles, fft_rst_n low exactly 2 cycles, then timeout_err pulse, no peak_valid, ch_done pulses.
- Non-granted channel toggles ch_adc_valid during RUN → no effect on fft_adc_valid or fft_adc_input.
- rst asserted mid-RUN → next cycle all outputs at reset values; fft_rst_n=0 until rst falls; a held request is granted again after reset release.

Source files
------------

// File: rtl/fft_sched.sv
// Round-robin scheduler that shares one spectrum engine between NUM_CH ADC channels,
// tracks the peak magnitude bin of each run and recovers a hung engine by watchdog.
module fft_sched #(
    parameter int NUM_CH         = 4,
    parameter int FFT_SIZE       = 2048,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    ch_req,
    input  logic [16*NUM_CH-1:0] ch_adc_data,
    input  logic [NUM_CH-1:0]    ch_adc_valid,
    output logic [NUM_CH-1:0]    ch_grant,
    output logic [NUM_CH-1:0]    ch_done,
    output logic                 fft_rst_n,
    output logic                 fft_enable,
    output logic [15:0]          fft_adc_input,
    output logic                 fft_adc_valid,
    input  logic [27:0]          fft_magnitude,
    input  logic [10:0]          fft_bin_index,
    input  logic                 fft_magnitude_valid,
    input  logic                 fft_processing_done,
    output logic [2:0]           peak_ch,
    output logic [10:0]          peak_bin,
    output logic [27:0]          peak_mag,
    output logic                 peak_valid,
    output logic                 timeout_err
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [11:0]     BIN_LIMIT = 12'(FFT_SIZE / 2);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, RECOVER, RESULT} state_t;

    state_t            state;
    state_t            next_state;
    logic [CH_W-1:0]   grant_idx;
    logic [CH_W-1:0]   last_grant;
    logic [CH_W-1:0]   win_idx;
    logic [WD_W-1:0]   watchdog;
    logic              rec_cnt;
    logic              aborted;
    logic [27:0]       run_mag;
    logic [10:0]       run_bin;
    logic              bin_in_range;

    // First requester found scanning from last+1 with wraparound.
    function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                input logic [CH_W-1:0]   last);
        logic [CH_W-1:0] pick;
        pick = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            if (req[(int'(last) + i) % NUM_CH])
                pick = CH_W'((int'(last) + i) % NUM_CH);
        end
        return pick;
    endfunction

    assign win_idx      = rr_pick(ch_req, last_grant);
    assign bin_in_range = (fft_bin_index != 11'd0) && ({1'b0, fft_bin_index} < BIN_LIMIT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (|ch_req) next_state = RUN;
            RUN: begin
                if (fft_processing_done)   next_state = DRAIN;
                else if (watchdog == WD_LAST) next_state = RECOVER;
            end
            DRAIN:   if (!fft_processing_done) next_state = RESULT;
            RECOVER: if (rec_cnt) next_state = RESULT;
            RESULT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        fft_adc_input = '0;
        fft_adc_valid = 1'b0;
        ch_done       = '0;
        peak_valid    = 1'b0;
        timeout_err   = 1'b0;
        if (state == RUN) begin
            fft_adc_input = ch_adc_data[{grant_idx, 4'b0000} +: 16];
            fft_adc_valid = ch_adc_valid[grant_idx];
        end
        if (state == RESULT) begin
            ch_done     = ch_grant;
            peak_valid  = !aborted;
            timeout_err = aborted;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_grant   <= '0;
            grant_idx  <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
            fft_enable <= 1'b0;
            fft_rst_n  <= 1'b0;
            watchdog   <= '0;
            rec_cnt    <= 1'b0;
            aborted    <= 1'b0;
            run_mag    <= '0;
            run_bin    <= '0;
            peak_ch    <= '0;
            peak_bin   <= '0;
            peak_mag   <= '0;
        end else begin
            // Engine reset is held low for exactly the cycles spent in RECOVER.
            fft_rst_n <= (next_state != RECOVER);
            case (state)
                IDLE: begin
                    if (|ch_req) begin
                        grant_idx  <= win_idx;
                        ch_grant   <= NUM_CH'(1) << win_idx;
                        fft_enable <= 1'b1;
                        watchdog   <= '0;
                        aborted    <= 1'b0;
                        run_mag    <= '0;
                        run_bin    <= '0;
                    end
                end
                RUN: begin
                    watchdog <= watchdog + 1'b1;
                    // Strict compare: with bins arriving in order, ties keep the lower bin.
                    if (fft_magnitude_valid && bin_in_range && (fft_magnitude > run_mag)) begin
                        run_mag <= fft_magnitude;
                        run_bin <= fft_bin_index;
                    end
                    if (fft_processing_done) begin
                        fft_enable <= 1'b0;
                    end else if (watchdog == WD_LAST) begin
                        fft_enable <= 1'b0;
                        aborted    <= 1'b1;
                        rec_cnt    <= 1'b0;
                    end
                end
                RECOVER: rec_cnt <= 1'b1;
                RESULT: begin
                    ch_grant   <= '0;
                    last_grant <= grant_idx;
                end
                default: ;
            endcase
            // Publish on entry to RESULT so the strobe and the data line up.
            if ((next_state == RESULT) && (state != RESULT) && !aborted) begin
                peak_ch  <= 3'(grant_idx);
                peak_bin <= run_bin;
                peak_mag <= run_mag;
            end
        end
    end

endmodule

// File: tb/tb_fft_sched.sv
// Self-checking bench for fft_sched: directed and random runs against a
// behavioural engine/arbitration model kept in the bench.
module tb_fft_sched;

    localparam int NCH  = 4;
    localparam int HALF = 128;

    logic              clk;
    logic              rst;
    logic [NCH-1:0]    ch_req;
    logic [16*NCH-1:0] ch_adc_data;
    logic [NCH-1:0]    ch_adc_valid;
    logic [NCH-1:0]    ch_grant;
    logic [NCH-1:0]    ch_done;
    logic              fft_rst_n;
    logic              fft_enable;
    logic [15:0]       fft_adc_input;
    logic              fft_adc_valid;
    logic [27:0]       fft_magnitude;
    logic [10:0]       fft_bin_index;
    logic              fft_magnitude_valid;
    logic              fft_processing_done;
    logic [2:0]        peak_ch;
    logic [10:0]       peak_bin;
    logic [27:0]       peak_mag;
    logic              peak_valid;
    logic              timeout_err;

    fft_sched #(.NUM_CH(NCH), .FFT_SIZE(256), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .ch_req(ch_req), .ch_adc_data(ch_adc_data),
        .ch_adc_valid(ch_adc_valid), .ch_grant(ch_grant), .ch_done(ch_done),
        .fft_rst_n(fft_rst_n), .fft_enable(fft_enable), .fft_adc_input(fft_adc_input),
        .fft_adc_valid(fft_adc_valid), .fft_magnitude(fft_magnitude),
        .fft_bin_index(fft_bin_index), .fft_magnitude_valid(fft_magnitude_valid),
        .fft_processing_done(fft_processing_done), .peak_ch(peak_ch), .peak_bin(peak_bin),
        .peak_mag(peak_mag), .peak_valid(peak_valid), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;
    int last_ch = NCH - 1;

    logic [10:0] q_bin[$];
    logic [27:0] q_mag[$];
    logic [2:0]  exp_pch;
    logic [10:0] exp_pbin;
    logic [27:0] exp_pmag;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Arbitration rule: first requester after the last served channel, wrapping.
    function automatic int model_pick(input logic [NCH-1:0] req, input int last);
        for (int k = 1; k <= NCH; k++)
            if (req[(last + k) % NCH]) return (last + k) % NCH;
        return -1;
    endfunction

    // Peak rule: largest magnitude over bins 1..HALF-1, lowest bin on ties, else 0/0.
    task automatic model_peak(output int b, output logic [27:0] m);
        b = 0;
        m = '0;
        for (int i = 0; i < q_bin.size(); i++) begin
            if (q_bin[i] >= 1 && q_bin[i] < HALF) begin
                if (q_mag[i] > m || (q_mag[i] == m && m != 0 && int'(q_bin[i]) < b)) begin
                    m = q_mag[i];
                    b = int'(q_bin[i]);
                end
            end
        end
    endtask

    task automatic push(input int b, input logic [27:0] m);
        q_bin.push_back(11'(b));
        q_mag.push_back(m);
    endtask

    task automatic gen_list();
        int b;
        q_bin.delete();
        q_mag.delete();
        b = $urandom_range(0, 2);
        repeat ($urandom_range(0, 30)) begin
            push(b, ($urandom_range(0, 3) == 0) ? 28'h0000800 : 28'($urandom()));
            b += $urandom_range(1, 15);
        end
    endtask

    task automatic drive_adc();
        ch_adc_data  = {$urandom(), $urandom()};
        ch_adc_valid = 4'($urandom());
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"},     64'(ch_grant),      64'd0);
        check({tag, "_done"},      64'(ch_done),       64'd0);
        check({tag, "_rst_n"},     64'(fft_rst_n),     64'd0);
        check({tag, "_enable"},    64'(fft_enable),    64'd0);
        check({tag, "_adc_in"},    64'(fft_adc_input), 64'd0);
        check({tag, "_adc_valid"}, 64'(fft_adc_valid), 64'd0);
        check({tag, "_peak_ch"},   64'(peak_ch),       64'd0);
        check({tag, "_peak_bin"},  64'(peak_bin),      64'd0);
        check({tag, "_peak_mag"},  64'(peak_mag),      64'd0);
        check({tag, "_peak_valid"},64'(peak_valid),    64'd0);
        check({tag, "_timeout"},   64'(timeout_err),   64'd0);
    endtask

    // Called at an IDLE negedge with requests already driven.
    task automatic wait_grant(input int exp_ch);
        int cnt;
        cnt = 0;
        while (ch_grant == '0 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("grant_latency", 64'(cnt), 64'd1);
        check("grant",         64'(ch_grant), 64'(4'(1) << exp_ch));
        check("enable_on",     64'(fft_enable), 64'd1);
    endtask

    // Called at the first RUN negedge; streams the queued bins, then the done handshake.
    task automatic engine_run(input int ch);
        int          exp_b;
        logic [27:0] exp_m;
        model_peak(exp_b, exp_m);
        for (int i = 0; i < q_bin.size(); i++) begin
            fft_magnitude_valid = 1'b1;
            fft_bin_index       = q_bin[i];
            fft_magnitude       = q_mag[i];
            drive_adc();
            #1;
            check("adc_valid", 64'(fft_adc_valid), 64'(ch_adc_valid[ch]));
            check("adc_input", 64'(fft_adc_input), 64'(ch_adc_data[16*ch +: 16]));
            @(negedge clk);
        end
        fft_magnitude_valid = 1'b0;
        fft_processing_done = 1'b1;
        @(negedge clk);
        check("enable_drop", 64'(fft_enable), 64'd0);
        fft_processing_done = 1'b0;
        @(negedge clk);
        check("done_pulse",    64'(ch_done),     64'(4'(1) << ch));
        check("peak_valid",    64'(peak_valid),  64'd1);
        check("timeout_quiet", 64'(timeout_err), 64'd0);
        check("peak_ch",       64'(peak_ch),     64'(ch));
        check("peak_bin",      64'(peak_bin),    64'(exp_b));
        check("peak_mag",      64'(peak_mag),    64'(exp_m));
        exp_pch  = 3'(ch);
        exp_pbin = 11'(exp_b);
        exp_pmag = exp_m;
        last_ch  = ch;
        @(negedge clk);
        check("idle_grant",     64'(ch_grant),      64'd0);
        check("done_once",      64'(ch_done),       64'd0);
        check("valid_once",     64'(peak_valid),    64'd0);
        check("idle_adc_valid", 64'(fft_adc_valid), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed no end of test, expected $finish");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        int w;
        int cnt;
        rst = 1'b1;
        ch_req = '0;
        ch_adc_data = '0;
        ch_adc_valid = '0;
        fft_magnitude = '0;
        fft_bin_index = '0;
        fft_magnitude_valid = 1'b0;
        fft_processing_done = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("rst_n_release", 64'(fft_rst_n), 64'd1);

        // Single request on ch1, tone at bin 100.
        q_bin.delete(); q_mag.delete();
        for (int b = 95; b <= 105; b++) push(b, (b == 100) ? 28'h0100000 : 28'h0000010);
        ch_req = 4'b0010;
        w = model_pick(ch_req, last_ch);
        wait_grant(w);
        engine_run(w);
        ch_req = '0;

        // Only DC and out-of-range bins: result is bin 0, magnitude 0.
        q_bin.delete(); q_mag.delete();
        push(0, 28'h0000123); push(128, 28'h0000999); push(500, 28'h0000055);
        ch_req = 4'b1000;
        w = model_pick(ch_req, last_ch);
        wait_grant(w);
        engine_run(w);
        ch_req = '0;

        // Tie between bins 5 and 7; huge DC and upper-half bins must be ignored.
        q_bin.delete(); q_mag.delete();
        push(0, 28'hFFFFFFF); push(3, 28'h0000010); push(5, 28'h0000800);
        push(7, 28'h0000800); push(200, 28'hFFFFFF0);
        ch_req = 4'b0100;
        w = model_pick(ch_req, last_ch);
        wait_grant(w);
        engine_run(w);
        ch_req = '0;

        // ch0 and ch2 request continuously: grants alternate.
        ch_req = 4'b0101;
        for (int r = 0; r < 4; r++) begin
            w = model_pick(ch_req, last_ch);
            gen_list();
            wait_grant(w);
            engine_run(w);
        end
        ch_req = '0;

        // Random request patterns and magnitude streams.
        for (int r = 0; r < 6; r++) begin
            ch_req = 4'($urandom_range(1, 15));
            w = model_pick(ch_req, last_ch);
            gen_list();
            wait_grant(w);
            engine_run(w);
            ch_req = '0;
        end

        // Engine never finishes: watchdog abort on ch3.
        ch_req = 4'b1000;
        w = model_pick(ch_req, last_ch);
        wait_grant(w);
        cnt = 0;
        while (fft_enable && cnt < 200) begin
            drive_adc();
            cnt++;
            @(negedge clk);
        end
        check("timeout_run_cycles", 64'(cnt), 64'd64);
        check("recover_rst_n_1",    64'(fft_rst_n), 64'd0);
        @(negedge clk);
        check("recover_rst_n_2",    64'(fft_rst_n), 64'd0);
        check("recover_no_err_yet", 64'(timeout_err), 64'd0);
        @(negedge clk);
        check("timeout_err",        64'(timeout_err), 64'd1);
        check("timeout_no_valid",   64'(peak_valid),  64'd0);
        check("timeout_done",       64'(ch_done),     64'(4'(1) << w));
        check("timeout_rst_n_back", 64'(fft_rst_n),   64'd1);
        check("timeout_keep_ch",    64'(peak_ch),     64'(exp_pch));
        check("timeout_keep_bin",   64'(peak_bin),    64'(exp_pbin));
        check("timeout_keep_mag",   64'(peak_mag),    64'(exp_pmag));
        last_ch = w;
        ch_req = '0;
        @(negedge clk);
        check("timeout_err_once",   64'(timeout_err), 64'd0);
        check("timeout_idle_grant", 64'(ch_grant),    64'd0);

        // Reset in the middle of a run; the held request is served again afterwards.
        ch_req = 4'b1000;
        w = model_pick(ch_req, last_ch);
        wait_grant(w);
        for (int i = 0; i < 3; i++) begin
            fft_magnitude_valid = 1'b1;
            fft_bin_index = 11'(10 + i);
            fft_magnitude = 28'h0ABCDEF;
            @(negedge clk);
        end
        fft_magnitude_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrun_reset");
        @(negedge clk);
        check("reset_hold_rst_n", 64'(fft_rst_n), 64'd0);
        check("reset_hold_grant", 64'(ch_grant),  64'd0);
        rst = 1'b0;
        last_ch = NCH - 1;
        w = model_pick(ch_req, last_ch);
        @(negedge clk);
        check("post_reset_rst_n",  64'(fft_rst_n),  64'd1);
        check("post_reset_grant",  64'(ch_grant),   64'(4'(1) << w));
        check("post_reset_enable", 64'(fft_enable), 64'd1);
        gen_list();
        engine_run(w);
        ch_req = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
